// File: rtl/t05_pkg.sv
// Shared types for the memory arbiter: FSM state, transaction owner and kind,
// plus the timeout counter width helper.
package t05_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    typedef enum logic {
        K_READ  = 1'b0,
        K_WRITE = 1'b1
    } kind_t;

    // Width able to hold 0..timeout; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/t05_mem_arbiter.sv
// Two-requester memory arbiter (data over fetch) driving one external memory
// port with a single outstanding transaction and a busy timeout.
module t05_mem_arbiter
    import t05_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_rreq,
    input  logic              d_wreq,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              freeze,
    output logic              err
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    owner_t           owner;
    kind_t            kind;
    logic [CNT_W-1:0] cnt;

    // Handshake: a requester raises its req level and holds it until its ack
    // pulse; it must drop req during the ack cycle or it is taken as a new
    // request in the following IDLE. Requests are only looked at in IDLE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            owner     <= OWN_INSTR;
            kind      <= K_READ;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wreq) begin
                        owner     <= OWN_DATA;
                        kind      <= K_WRITE;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= 1'b1;
                        state     <= ISSUE;
                    end else if (d_rreq) begin
                        owner    <= OWN_DATA;
                        kind     <= K_READ;
                        mem_addr <= d_addr;
                        mem_read <= 1'b1;
                        state    <= ISSUE;
                    end else if (i_req) begin
                        owner    <= OWN_INSTR;
                        kind     <= K_READ;
                        mem_addr <= i_addr;
                        mem_read <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!mem_busy || cnt == CNT_LAST) begin
                        // Timed-out reads return zero; writes leave rdata alone.
                        if (kind == K_READ) begin
                            if (owner == OWN_INSTR) begin
                                i_rdata <= mem_busy ? '0 : mem_rdata;
                            end else begin
                                d_rdata <= mem_busy ? '0 : mem_rdata;
                            end
                        end
                        i_ack <= (owner == OWN_INSTR);
                        d_ack <= (owner == OWN_DATA);
                        err   <= mem_busy;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by nRst so the stall also drops at once while reset is asserted.
    assign freeze = nRst & (i_req | d_rreq | d_wreq) & ~(i_ack | d_ack);

endmodule

// File: tb/tb_t05_mem_arbiter.sv
// Directed bench for t05_mem_arbiter: table of single transactions plus
// hand-written sequences for priority, timeout, reset and held requests.
module tb_t05_mem_arbiter;
    import t05_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          nRst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_rreq = 1'b0;
    logic          d_wreq = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_busy = 1'b0;
    logic          freeze;
    logic          err;

    int total = 0;
    int bad = 0;

    // kind: 0 fetch, 1 load, 2 store
    typedef struct {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mrdata;
        int            busy_n;
        int            exp_ack;
        logic [DW-1:0] exp_i;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    t05_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_rreq   (d_rreq),
        .d_wreq   (d_wreq),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy),
        .freeze   (freeze),
        .err      (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle, ends in the IDLE cycle after DONE.
    task automatic run_txn(input vec_t v);
        int   cyc;
        int   issue_cyc;
        int   ack_cyc;
        int   strobes;
        logic hold_bad;
        logic both_seen;
        i_req     = (v.kind == 2'd0);
        d_rreq    = (v.kind == 2'd1);
        d_wreq    = (v.kind == 2'd2);
        i_addr    = v.addr;
        d_addr    = v.addr;
        d_wdata   = v.wdata;
        mem_rdata = v.mrdata;
        mem_busy  = 1'b0;
        #1;
        check("freeze_on_req", freeze, 1);
        cyc = 1; issue_cyc = 0; ack_cyc = 0; strobes = 0;
        hold_bad = 1'b0; both_seen = 1'b0;
        for (int k = 0; k < 30 && ack_cyc == 0; k++) begin
            step();
            cyc++;
            if (mem_read && mem_write) both_seen = 1'b1;
            if (mem_read || mem_write) begin
                strobes++;
                if (issue_cyc == 0) issue_cyc = cyc;
                check("issue_addr", mem_addr, v.addr);
                check("issue_is_write", mem_write, (v.kind == 2'd2));
                if (v.kind == 2'd2) check("issue_wdata", mem_wdata, v.wdata);
            end else if (issue_cyc != 0) begin
                if (mem_addr !== v.addr || (v.kind == 2'd2 && mem_wdata !== v.wdata))
                    hold_bad = 1'b1;
            end
            if (i_ack || d_ack) begin
                ack_cyc = cyc;
                check("ack_owner", {i_ack, d_ack}, (v.kind == 2'd0) ? 2'b10 : 2'b01);
                check("freeze_on_ack", freeze, 0);
                check("err_on_ack", err, 0);
            end else begin
                check("freeze_pending", freeze, 1);
                if (issue_cyc != 0 && cyc > issue_cyc)
                    mem_busy = ((cyc - issue_cyc) <= v.busy_n);
                else
                    mem_busy = (v.busy_n > 0);
            end
        end
        check("ack_cycle", ack_cyc, v.exp_ack);
        check("strobe_count", strobes, 1);
        check("addr_data_held", hold_bad, 0);
        check("strobes_exclusive", both_seen, 0);
        i_req = 1'b0; d_rreq = 1'b0; d_wreq = 1'b0; mem_busy = 1'b0;
        step();
        check("ack_single_cycle", {i_ack, d_ack}, 2'b00);
        check("i_rdata_after", i_rdata, v.exp_i);
        check("d_rdata_after", d_rdata, v.exp_d);
        check("state_back_idle", dut.state, IDLE);
    endtask

    initial begin
        vecs[0] = '{kind: 2'd0, addr: 32'h0000_0040, wdata: 32'h0, mrdata: 32'h0051_0113,
                    busy_n: 0, exp_ack: 4, exp_i: 32'h0051_0113, exp_d: 32'h0};
        vecs[1] = '{kind: 2'd2, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, mrdata: 32'h1357_9BDF,
                    busy_n: 3, exp_ack: 7, exp_i: 32'h0051_0113, exp_d: 32'h0};
        vecs[2] = '{kind: 2'd1, addr: 32'h0000_0200, wdata: 32'h0, mrdata: 32'hCAFE_F00D,
                    busy_n: 1, exp_ack: 5, exp_i: 32'h0051_0113, exp_d: 32'hCAFE_F00D};
        vecs[3] = '{kind: 2'd0, addr: 32'h0000_0044, wdata: 32'h0, mrdata: 32'h1234_5678,
                    busy_n: 2, exp_ack: 6, exp_i: 32'h1234_5678, exp_d: 32'hCAFE_F00D};
        vecs[4] = '{kind: 2'd2, addr: 32'h0000_0104, wdata: 32'h0BAD_F00D, mrdata: 32'hAAAA_5555,
                    busy_n: 0, exp_ack: 4, exp_i: 32'h1234_5678, exp_d: 32'hCAFE_F00D};
        vecs[5] = '{kind: 2'd1, addr: 32'hFFFF_FFFC, wdata: 32'h0, mrdata: 32'hFFFF_FFFF,
                    busy_n: 3, exp_ack: 7, exp_i: 32'h1234_5678, exp_d: 32'hFFFF_FFFF};

        // Reset state, with a request already high.
        i_req = 1'b1;
        #2;
        check("rst_state", dut.state, IDLE);
        check("rst_strobes", {mem_read, mem_write}, 2'b00);
        check("rst_acks_err", {i_ack, d_ack, err}, 3'b000);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        check("rst_freeze", freeze, 0);
        repeat (2) @(posedge clk);
        #3;
        i_req = 1'b0;
        nRst = 1'b1;
        step();

        for (int n = 0; n < 6; n++) run_txn(vecs[n]);

        // Simultaneous requests: service order write, read, fetch.
        begin
            logic [AW:0] exp_q[$];
            logic [1:0]  ack_q[$];
            int          acks;
            int          strobes;
            logic        both_seen;
            exp_q.push_back({1'b1, 32'h0000_0500});
            exp_q.push_back({1'b0, 32'h0000_0500});
            exp_q.push_back({1'b0, 32'h0000_0400});
            ack_q.push_back(2'b01);
            ack_q.push_back(2'b01);
            ack_q.push_back(2'b10);
            i_addr = 32'h0000_0400; d_addr = 32'h0000_0500;
            d_wdata = 32'h1111_2222; mem_rdata = 32'h3333_4444; mem_busy = 1'b0;
            i_req = 1'b1; d_rreq = 1'b1; d_wreq = 1'b1;
            acks = 0; strobes = 0; both_seen = 1'b0;
            for (int k = 0; k < 40 && acks < 3; k++) begin
                step();
                if (mem_read && mem_write) both_seen = 1'b1;
                if (mem_read || mem_write) begin
                    strobes++;
                    if (exp_q.size() > 0) check("sim_order", {mem_write, mem_addr}, exp_q.pop_front());
                end
                if (i_ack || d_ack) begin
                    acks++;
                    if (ack_q.size() > 0) check("sim_ack_order", {i_ack, d_ack}, ack_q.pop_front());
                    if (d_ack && d_wreq) d_wreq = 1'b0;
                    else if (d_ack) d_rreq = 1'b0;
                    if (i_ack) i_req = 1'b0;
                end
            end
            check("sim_acks", acks, 3);
            check("sim_strobes", strobes, 3);
            check("sim_exclusive", both_seen, 0);
            check("sim_queue_empty", exp_q.size(), 0);
            step();
            check("sim_d_rdata", d_rdata, 32'h3333_4444);
            check("sim_i_rdata", i_rdata, 32'h3333_4444);
        end

        // Timeout: busy never drops, TIMEOUT=4 WAIT cycles then DONE with err.
        begin
            int   cyc;
            int   ack_cyc;
            logic err_early;
            d_rreq = 1'b1; d_addr = 32'h0000_0600; mem_rdata = 32'h5555_AAAA; mem_busy = 1'b1;
            cyc = 1; ack_cyc = 0; err_early = 1'b0;
            for (int k = 0; k < 30 && ack_cyc == 0; k++) begin
                step();
                cyc++;
                if (d_ack) begin
                    ack_cyc = cyc;
                    check("to_err_with_ack", err, 1);
                    check("to_d_rdata_zero", d_rdata, 0);
                end else if (err) begin
                    err_early = 1'b1;
                end
            end
            check("to_ack_cycle", ack_cyc, 7);
            check("to_no_early_err", err_early, 0);
            d_rreq = 1'b0; mem_busy = 1'b0;
            step();
            check("to_state_idle", dut.state, IDLE);
            check("to_err_cleared", {err, d_ack}, 2'b00);
        end

        // Reset during WAIT of a fetch, then re-issue of the held request.
        begin
            vec_t v;
            logic ack_seen;
            i_req = 1'b1; i_addr = 32'h0000_0080; mem_busy = 1'b1; mem_rdata = 32'h0000_0077;
            step();
            check("rm_issue", mem_read, 1);
            step();
            check("rm_in_wait", dut.state, WAIT);
            #2;
            nRst = 1'b0;
            #1;
            check("rm_async_state", dut.state, IDLE);
            check("rm_async_mem_addr", mem_addr, 0);
            check("rm_async_rdata", {i_rdata, d_rdata}, 0);
            check("rm_async_freeze", freeze, 0);
            check("rm_async_flags", {mem_read, mem_write, i_ack, d_ack, err}, 5'b0);
            ack_seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                if (i_ack) ack_seen = 1'b1;
            end
            check("rm_no_ack", ack_seen, 0);
            #2;
            nRst = 1'b1;
            v = '{kind: 2'd0, addr: 32'h0000_0080, wdata: 32'h0, mrdata: 32'h0000_0077,
                  busy_n: 0, exp_ack: 4, exp_i: 32'h0000_0077, exp_d: 32'h0};
            run_txn(v);
        end

        // Held fetch request: second transaction after exactly one IDLE cycle.
        begin
            int strobe_cyc[$];
            int ack_cyc[$];
            int cyc;
            i_req = 1'b1; i_addr = 32'h0000_0090; mem_rdata = 32'h0000_0099; mem_busy = 1'b0;
            cyc = 1;
            for (int k = 0; k < 20 && ack_cyc.size() < 2; k++) begin
                step();
                cyc++;
                if (mem_read) strobe_cyc.push_back(cyc);
                if (i_ack) begin
                    ack_cyc.push_back(cyc);
                    if (ack_cyc.size() == 2) i_req = 1'b0;
                end
            end
            check("held_strobes", strobe_cyc.size(), 2);
            check("held_acks", ack_cyc.size(), 2);
            if (strobe_cyc.size() == 2 && ack_cyc.size() == 2) begin
                check("held_first_issue", strobe_cyc[0], 2);
                check("held_first_ack", ack_cyc[0], 4);
                check("held_second_issue", strobe_cyc[1], 6);
                check("held_second_ack", ack_cyc[1], 8);
            end
            step();
            check("held_i_rdata", i_rdata, 32'h0000_0099);
            check("held_idle", dut.state, IDLE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t05_mem_arbiter.md
Name: t05_mem_arbiter

Overview:
- Shares the single external memory port between two requesters: the instruction fetch unit and the data path (ALU load/store address and store data).
- Sequences exactly one outstanding memory transaction at a time.
- Returns read data and a one-cycle ack to the winning requester.
- Drives a freeze signal that stalls the core while any request is in flight.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 255, maximum cycles to wait on mem_busy before aborting the transaction; minimum legal value is 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nRst  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; level, held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched instruction; valid in the i_ack cycle.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_rreq  in  1  load request; level, held until d_ack.
- d_wreq  in  1  store request; level, held until d_ack.
- d_addr  in  ADDR_W  load/store address (ALU read/write address).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle data completion pulse.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_busy  in  1  memory busy; the transaction completes in the first cycle after issue with mem_busy=0.
- freeze  out  1  core stall.
- err  out  1  one-cycle pulse with ack when the transaction timed out.

Behaviour:
- Reset (nRst=0, asynchronous):
  - state=IDLE.
  - All outputs 0: acks, strobes, mem_addr, mem_wdata, i_rdata, d_rdata, freeze, err.
  - Timeout counter 0.
  - A transaction in flight is abandoned; no ack is ever produced for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled. Priority, highest first: d_wreq, d_rreq, i_req.
  - The data requester wins over fetch because it belongs to the instruction already executing.
  - If d_wreq and d_rreq are both high, the write is serviced first; the read remains pending and is serviced in the next IDLE.
  - Winner's address and write data are registered into mem_addr/mem_wdata, plus an owner/kind register; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle): mem_read or mem_write=1 according to kind; mem_addr/mem_wdata held; counter cleared; go to WAIT.
- WAIT:
  - Strobes are 0 and mem_addr/mem_wdata are held.
  - mem_busy=0: capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
  - mem_busy=1: counter increments.
  - Counter reaches TIMEOUT: go to DONE with err flagged and rdata forced to 0.
- DONE (exactly 1 cycle):
  - Owner's ack=1; err=1 if timed out; go to IDLE.
  - The requester must drop its req in the DONE cycle. A req still high in the following IDLE is treated as a new transaction.
- rdata registers hold their last value between transactions.
  - A write transaction never changes d_rdata.
- freeze = (any req high) AND NOT (ack asserted this cycle). freeze is combinational from the req inputs and registered state.
- Minimum latency, request to ack: 4 cycles, i.e. IDLE sample, ISSUE, WAIT with busy=0, DONE.
- Back-to-back transactions: one IDLE cycle separates them.
- Request inputs that change while not in IDLE are ignored until the next IDLE.
- mem_read and mem_write are never high together.

Decomposition:
- Shared package t05_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - owner enum {OWN_INSTR, OWN_DATA}.
  - kind enum {K_READ, K_WRITE}.
- No sub-module: single FSM plus a timeout counter. The counter stays inline.

Test Plan:
- Fetch only:
  - Stimulus: i_req=1, i_addr=0x0000_0040, mem_busy=0, mem_rdata=0x0051_0113.
  - Required: mem_read for 1 cycle at addr 0x40; i_ack on cycle 4 with i_rdata=0x0051_0113; freeze high through cycle 3, low on ack.
- Store with wait states:
  - Stimulus: d_wreq=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, mem_busy high for 3 cycles after issue.
  - Required: single mem_write pulse; addr/data held throughout; d_ack on cycle 7; d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: i_req, d_rreq and d_wreq all high in the same IDLE cycle.
  - Required: order of service is write, read, fetch; three separate acks; mem_read and mem_write never high together.
- Timeout:
  - Stimulus: TIMEOUT=4, d_rreq=1, mem_busy held at 1.
  - Required: d_ack and err pulse together after 4 WAIT cycles; d_rdata=0; FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: nRst pulled low during WAIT of a fetch.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no i_ack; after release the held i_req is re-issued from IDLE.
- Held request:
  - Stimulus: i_req kept high through DONE.
  - Required: a second fetch is issued with exactly one IDLE cycle between the two transactions.
